jam_perm_gen: RTL
=================

Name: jam_perm_gen

Overview:
- Lexicographic permutation generator for the JAM job-assignment engine. Sits directly upstream of the cost-accumulate/compare stage.
- Each presented permutation is one worker-to-job assignment. Element i is the job index J given to worker W=i, and the accumulator walks W=0..N-1 against the cost ROM.
- Enumerates all N! assignments exactly once, in ascending lexicographic order, under a valid/ready handshake.

Parameters:
- N, 8, number of workers/jobs; legal range 2..8.
- IDX_W, 3, bits per job index; must satisfy 2^IDX_W >= N.
- CNT_W, 16, width of permutation index counter; must hold N!-1 (40319 for N=8).

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin enumeration; sampled only in IDLE.
- perm_ready  input  1  consumer accepts perm when perm_valid&&perm_ready at a rising edge.
- perm_valid  output  1  perm/perm_index/perm_last are valid and held stable.
- perm  output  N*IDX_W  packed permutation; perm[IDX_W*i +: IDX_W] = job for worker i; element 0 most significant for ordering.
- perm_index  output  CNT_W  ordinal of the presented permutation, 0..N!-1.
- perm_last  output  1  presented permutation is the final one (strictly descending).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last permutation is accepted.

Behaviour:
Reset (RST low, asynchronous):
- State goes to IDLE.
- perm_valid=0, perm_last=0, busy=0, done=0, perm_index=0.
- perm register loads identity (p[i]=i).
- Reset asserted mid-enumeration aborts immediately; there is no resume.

FSM states: IDLE, OUT, CALC, SWAP, REV.
- IDLE:
  - done=0 except its pulse cycle.
  - start=1: load identity, perm_index=0, go to OUT.
  - Outputs become visible the cycle after start.
- OUT:
  - perm_valid=1; perm and perm_index are held stable until accepted.
  - perm_last = 1 iff no i in 0..N-2 satisfies p[i]<p[i+1].
  - On accept with perm_last=0: go to CALC.
  - On accept with perm_last=1: go to IDLE and assert done for exactly that next cycle.
  - perm_ready may stay high continuously; one accept occurs per OUT visit.
- CALC (1 cycle, perm_valid=0):
  - pivot k = largest i < N-1 with p[i]<p[i+1].
  - partner m = largest j > k with p[j]>p[k].
  - Both are computed combinationally and registered.
- SWAP (1 cycle):
  - Exchange p[k] and p[m].
  - Set lo=k+1, hi=N-1.
  - If lo<hi go to REV, else go to OUT.
- REV:
  - Each cycle: exchange p[lo], p[hi]; lo++, hi--.
  - When the post-update lo>=hi, go to OUT.
  - Number of REV cycles = floor((N-1-k)/2).
- perm_index increments by 1 on the cycle the new permutation enters OUT, i.e. at the SWAP/REV→OUT transition.

Timing and handshake rules:
- Gap between accept and the next perm_valid = 2 + floor((N-1-k)/2) cycles; minimum 2.
- start while busy=1 is ignored with no side effects.
- start on the same cycle as done is ignored; done is issued from IDLE.
- perm_ready while perm_valid=0 has no effect.
- Permutation values are always a bijection on 0..N-1; no duplicate job index ever appears on perm.
- Unused perm_index upper bits are zero.

Test Plan:
- N=3, perm_ready tied 1, pulse start:
  - Required sequence: 012, 021, 102, 120, 201, 210, with perm_index 0..5.
  - perm_last=1 only on 210; done pulses once; busy falls in the same cycle done rises.
- N=8, perm_ready=1:
  - First perm 0,1,2,3,4,5,6,7; second 0,1,2,3,4,5,7,6, valid again exactly 2 cycles after the first accept.
  - Exactly 40320 accepts; last perm 7,6,5,4,3,2,1,0 with perm_index=40319.
  - Scoreboard checks every perm is a valid bijection and strictly greater than the previous one.
- Backpressure, N=4:
  - Hold perm_ready=0 for 5 cycles with perm_valid=1: perm and perm_index stay unchanged.
  - Then ready=1 for one cycle: advances exactly one permutation.
- Reverse-length check, N=8:
  - Accept 0,7,6,5,4,3,2,1 (k=0).
  - Next is 1,0,2,3,4,5,6,7 after exactly 2+3=5 valid-low cycles.
- Start while busy, N=4:
  - Pulse start at perm_index=3: no restart, sequence continues 4, 5, ...
- Reset mid-run, N=8:
  - Drop RST at perm_index=100: all outputs are 0 asynchronously and perm returns to identity.
  - A new start restarts at index 0 with the identity permutation.

Source files
------------

// File: rtl/jam_perm_gen_if.sv
// jam_perm_gen_if: permutation stream from the JAM permutation generator
// to the cost-accumulate stage.
//   perm_valid  generator -> consumer  perm/perm_index/perm_last are valid and held
//   perm_ready  consumer -> generator  accept on perm_valid && perm_ready at CLK rise
//   perm        generator -> consumer  perm[IDX_W*i +: IDX_W] = job for worker i
//   perm_index  generator -> consumer  ordinal of the presented permutation
//   perm_last   generator -> consumer  presented permutation is the final one
interface jam_perm_gen_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 16
);
  logic                 perm_valid;
  logic                 perm_ready;
  logic [N*IDX_W-1:0]   perm;
  logic [CNT_W-1:0]     perm_index;
  logic                 perm_last;

  modport master (
    output perm_valid,
    output perm,
    output perm_index,
    output perm_last,
    input  perm_ready
  );

  modport slave (
    input  perm_valid,
    input  perm,
    input  perm_index,
    input  perm_last,
    output perm_ready
  );
endinterface

// File: rtl/jam_perm_gen.sv
// jam_perm_gen: enumerates all N! worker-to-job assignments exactly once in
// ascending lexicographic order (element 0 most significant).
//   CLK       rising-edge clock
//   RST       asynchronous active-low reset
//   start     begin an enumeration (only honoured in IDLE)
//   busy      high in every state except IDLE
//   done      one-cycle pulse after the final permutation is accepted
//   perm_bus  permutation stream (master side of jam_perm_gen_if)
// Next-permutation step: find pivot k and partner m (CALC), swap them (SWAP),
// then reverse the tail p[k+1..N-1] one pair per cycle (REV).
module jam_perm_gen #(
  parameter int N     = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  output logic            busy,
  output logic            done,
  jam_perm_gen_if.master  perm_bus
);

  typedef enum logic [2:0] {IDLE, OUT, CALC, SWAP, REV} state_t;

  state_t                 state_reg;
  logic [IDX_W-1:0]       p_reg [N];
  logic [IDX_W-1:0]       k_reg;
  logic [IDX_W-1:0]       m_reg;
  logic [IDX_W-1:0]       lo_reg;
  logic [IDX_W-1:0]       hi_reg;
  logic [CNT_W-1:0]       perm_index_reg;
  logic                   done_reg;

  // Pivot/partner search over the current permutation. Later matches
  // overwrite earlier ones, so each loop yields the largest qualifying index.
  logic [IDX_W-1:0]       piv_k;
  logic [IDX_W-1:0]       part_m;
  logic                   has_ascent;

  always_comb begin
    piv_k      = '0;
    has_ascent = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if (p_reg[i] < p_reg[i+1]) begin
        piv_k      = IDX_W'(i);
        has_ascent = 1'b1;
      end
    end
    part_m = '0;
    for (int j = 0; j < N; j++) begin
      if ((IDX_W'(j) > piv_k) && (p_reg[j] > p_reg[piv_k])) begin
        part_m = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg      <= IDLE;
      done_reg       <= 1'b0;
      perm_index_reg <= '0;
      k_reg          <= '0;
      m_reg          <= '0;
      lo_reg         <= '0;
      hi_reg         <= '0;
      for (int i = 0; i < N; i++) begin
        p_reg[i] <= IDX_W'(i);
      end
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // done_reg high here means this is the done pulse cycle; a start
          // arriving with it belongs to the finished run and is dropped.
          if (start && !done_reg) begin
            for (int i = 0; i < N; i++) begin
              p_reg[i] <= IDX_W'(i);
            end
            perm_index_reg <= '0;
            state_reg      <= OUT;
          end
        end
        OUT: begin
          if (perm_bus.perm_ready) begin
            if (!has_ascent) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          k_reg     <= piv_k;
          m_reg     <= part_m;
          state_reg <= SWAP;
        end
        SWAP: begin
          p_reg[k_reg] <= p_reg[m_reg];
          p_reg[m_reg] <= p_reg[k_reg];
          lo_reg       <= k_reg + IDX_W'(1);
          hi_reg       <= IDX_W'(N - 1);
          if ((k_reg + IDX_W'(1)) < IDX_W'(N - 1)) begin
            state_reg <= REV;
          end else begin
            perm_index_reg <= perm_index_reg + CNT_W'(1);
            state_reg      <= OUT;
          end
        end
        REV: begin
          p_reg[lo_reg] <= p_reg[hi_reg];
          p_reg[hi_reg] <= p_reg[lo_reg];
          lo_reg        <= lo_reg + IDX_W'(1);
          hi_reg        <= hi_reg - IDX_W'(1);
          // lo < hi on entry guarantees hi >= 1, so hi-1 cannot wrap.
          if ((lo_reg + IDX_W'(1)) >= (hi_reg - IDX_W'(1))) begin
            perm_index_reg <= perm_index_reg + CNT_W'(1);
            state_reg      <= OUT;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pack
      assign perm_bus.perm[IDX_W*gi +: IDX_W] = p_reg[gi];
    end
  endgenerate

  // A permutation with no ascent is the strictly descending final one; the
  // flag is a decode of registered state and the held permutation.
  assign perm_bus.perm_valid = (state_reg == OUT);
  assign perm_bus.perm_last  = (state_reg == OUT) && !has_ascent;
  assign perm_bus.perm_index = perm_index_reg;
  assign busy                = (state_reg != IDLE);
  assign done                = done_reg;

endmodule
